// File: rtl/cac_settings_arbiter.sv
// cac_settings_arbiter
//   Shares the communication-and-control settings RAM between port A (UART
//   command channel) and port B (debug/local control). Each request is a single
//   word read or write. Arbitration is round-robin. The last-served port loses
//   a tie, so a waiting port is always served next.
//
//   Build option: define CAC_ARB_WPROT_EN to reject writes to the low
//   ROM_LENGTH words. Reads of that range are still allowed. Without the macro,
//   ROM_LENGTH has no effect.
//
//   Ports
//     clk_cac, rstb_cac             clock, asynchronous active-low reset
//     a_req/a_we/a_addr/a_wdata     port A request; req is held until a_ack
//     a_ack/a_err/a_rdata           port A one-cycle completion, error, read data
//     b_*                           same set for port B
//     mem_en/mem_we/mem_addr/mem_wdata  RAM strobe (one cycle) and command
//     mem_rdata                     RAM read data, MEM_RD_LAT cycles after mem_en
//     busy                          high whenever the FSM is not idle
module cac_settings_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int RAM_LENGTH = 64,
   parameter int ROM_LENGTH = 8,
   parameter int MEM_RD_LAT = 1
) (
   input  logic                  clk_cac,
   input  logic                  rstb_cac,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ack,
   output logic                  a_err,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ack,
   output logic                  b_err,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   // Comparisons use one extra bit, so RAM_LENGTH may equal 2**ADDR_WIDTH.
   localparam logic [ADDR_WIDTH:0] RAM_LEN_W = (ADDR_WIDTH+1)'(RAM_LENGTH);
   localparam logic [ADDR_WIDTH:0] ROM_LEN_W = (ADDR_WIDTH+1)'(ROM_LENGTH);
   localparam logic [1:0]          LAT_LAST  = 2'(MEM_RD_LAT - 1);
`ifdef CAC_ARB_WPROT_EN
   localparam bit WPROT_EN = 1'b1;
`else
   localparam bit WPROT_EN = 1'b0;
`endif

   state_t                state;
   logic                  gnt_b;      // granted port: 0 = A, 1 = B
   logic                  rr_last_b;  // last granted port: 0 = A, 1 = B
   logic [1:0]            wait_cnt;

   logic                  sel_b;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  reject;

   // B wins if it is the only requester, or if both request and A was served last.
   always_comb begin
      sel_b     = b_req & (~a_req | ~rr_last_b);
      sel_we    = sel_b ? b_we    : a_we;
      sel_addr  = sel_b ? b_addr  : a_addr;
      sel_wdata = sel_b ? b_wdata : a_wdata;
      reject    = ({1'b0, sel_addr} >= RAM_LEN_W) |
                  (WPROT_EN & sel_we & ({1'b0, sel_addr} < ROM_LEN_W));
   end

   assign busy = (state != IDLE);

   // The mem_we/mem_addr/mem_wdata registers also hold the granted command
   // until the access completes.
   always_ff @(posedge clk_cac or negedge rstb_cac) begin
      if (!rstb_cac) begin
         state     <= IDLE;
         gnt_b     <= 1'b0;
         rr_last_b <= 1'b1;
         wait_cnt  <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         a_ack     <= 1'b0;
         a_err     <= 1'b0;
         a_rdata   <= '0;
         b_ack     <= 1'b0;
         b_err     <= 1'b0;
         b_rdata   <= '0;
      end else begin
         mem_en  <= 1'b0;
         a_ack   <= 1'b0;
         a_err   <= 1'b0;
         a_rdata <= '0;
         b_ack   <= 1'b0;
         b_err   <= 1'b0;
         b_rdata <= '0;
         case (state)
            IDLE: begin
               if (a_req || b_req) begin
                  gnt_b     <= sel_b;
                  rr_last_b <= sel_b;
                  if (reject) begin
                     // Rejected accesses skip the RAM and complete on the next cycle.
                     state <= ACK;
                     if (sel_b) begin
                        b_ack <= 1'b1;
                        b_err <= 1'b1;
                     end else begin
                        a_ack <= 1'b1;
                        a_err <= 1'b1;
                     end
                  end else begin
                     state     <= ISSUE;
                     mem_en    <= 1'b1;
                     mem_we    <= sel_we;
                     mem_addr  <= sel_addr;
                     mem_wdata <= sel_wdata;
                  end
               end
            end
            ISSUE: begin
               state    <= WAIT;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (wait_cnt == LAT_LAST) begin
                  state <= ACK;
                  if (gnt_b) begin
                     b_ack   <= 1'b1;
                     b_rdata <= mem_we ? '0 : mem_rdata;
                  end else begin
                     a_ack   <= 1'b1;
                     a_rdata <= mem_we ? '0 : mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
